// File: rtl/pwm_demodulator.sv
// -----------------------------------------------------------------------------
// pwm_demodulator
//
// Splits a stream of 12-bit ADC samples by the phase of a switching PWM and
// reports the on-phase sum minus the off-phase sum over N_PERIODS PWM periods.
// Windows run back to back: the rising edge that closes one window also opens
// the next one.
//
// Parameters
//   N_PERIODS    PWM periods per demodulation window (1..255)
//   ACC_W        width of each unsigned phase accumulator (12..30)
//
// Ports
//   clk          system clock; all logic is on its rising edge
//   reset        synchronous, active-high reset
//   switch_pwm   switching PWM, asynchronous to clk
//   sample_valid one-clk strobe qualifying sample
//   sample       unsigned 12-bit ADC code
//   demod        on_sum - off_sum of the last window, two's complement
//   on_count     samples taken while the PWM was high in the last window
//   off_count    samples taken while the PWM was low in the last window
//   demod_valid  one-clk pulse marking a new set of results
//   overflow     an accumulator or counter saturated in the last window
// -----------------------------------------------------------------------------
module pwm_demodulator #(
    parameter int N_PERIODS = 8,
    parameter int ACC_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch_pwm,
    input  logic             sample_valid,
    input  logic [11:0]      sample,
    output logic [ACC_W:0]   demod,
    output logic [15:0]      on_count,
    output logic [15:0]      off_count,
    output logic             demod_valid,
    output logic             overflow
);

    localparam logic WAIT_EDGE = 1'b0;
    localparam logic ACCUM     = 1'b1;

    localparam logic [ACC_W-1:0] SUM_MAX     = '1;
    localparam logic [15:0]      CNT_MAX     = '1;
    localparam logic [7:0]       LAST_PERIOD = 8'(N_PERIODS - 1);

    logic             sync_q;
    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    logic             state;
    logic [7:0]       period_cnt;
    logic [ACC_W-1:0] on_sum;
    logic [ACC_W-1:0] off_sum;
    logic [15:0]      on_cnt;
    logic [15:0]      off_cnt;
    logic             win_ovf;

    // Saturating add of the current sample into whichever phase pwm_s selects
    logic [ACC_W-1:0] acc_sum;
    logic [15:0]      acc_cnt;
    logic [ACC_W:0]   sum_wide;
    logic             sum_sat;
    logic [ACC_W-1:0] sum_nxt;
    logic             cnt_sat;
    logic [15:0]      cnt_nxt;

    logic             close_win;
    logic             start_win;

    assign rise = pwm_s & ~pwm_d;

    // Closing edge: last period of the window has ended.
    assign close_win = rise && (state == ACCUM) && (period_cnt == LAST_PERIOD);
    // A window opens on the first edge out of WAIT_EDGE and on every closing edge.
    assign start_win = rise && ((state == WAIT_EDGE) || (period_cnt == LAST_PERIOD));

    always_comb begin
        acc_sum  = pwm_s ? on_sum : off_sum;
        acc_cnt  = pwm_s ? on_cnt : off_cnt;
        sum_wide = {1'b0, acc_sum} + (ACC_W+1)'(sample);
        sum_sat  = sum_wide[ACC_W];
        sum_nxt  = sum_sat ? SUM_MAX : sum_wide[ACC_W-1:0];
        cnt_sat  = (acc_cnt == CNT_MAX);
        cnt_nxt  = cnt_sat ? CNT_MAX : acc_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        demod_valid <= 1'b0;
        if (reset) begin
            sync_q     <= 1'b0;
            pwm_s      <= 1'b0;
            pwm_d      <= 1'b0;
            state      <= WAIT_EDGE;
            period_cnt <= '0;
            on_sum     <= '0;
            off_sum    <= '0;
            on_cnt     <= '0;
            off_cnt    <= '0;
            win_ovf    <= 1'b0;
            demod      <= '0;
            on_count   <= '0;
            off_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            sync_q <= switch_pwm;
            pwm_s  <= sync_q;
            pwm_d  <= pwm_s;

            // Results reflect the window as it stood before this cycle's sample.
            if (close_win) begin
                demod       <= {1'b0, on_sum} - {1'b0, off_sum};
                on_count    <= on_cnt;
                off_count   <= off_cnt;
                overflow    <= win_ovf;
                demod_valid <= 1'b1;
            end

            if (start_win) begin
                // pwm_s is high on a rise, so a same-cycle sample opens the on phase.
                state      <= ACCUM;
                period_cnt <= '0;
                off_sum    <= '0;
                off_cnt    <= '0;
                win_ovf    <= 1'b0;
                on_sum     <= sample_valid ? ACC_W'(sample) : '0;
                on_cnt     <= sample_valid ? 16'd1 : 16'd0;
            end else if (state == ACCUM) begin
                if (rise)
                    period_cnt <= period_cnt + 8'd1;
                if (sample_valid) begin
                    if (pwm_s) begin
                        on_sum <= sum_nxt;
                        on_cnt <= cnt_nxt;
                    end else begin
                        off_sum <= sum_nxt;
                        off_cnt <= cnt_nxt;
                    end
                    if (sum_sat || cnt_sat)
                        win_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_demodulator.sv
module tb_pwm_demodulator;

    localparam int N0 = 8;
    localparam int N1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        switch_pwm;
    logic        sample_valid;
    logic [11:0] sample;

    logic [24:0] demod0;
    logic [15:0] on0, off0;
    logic        dv0, ovf0;
    logic [12:0] demod1;
    logic [15:0] on1, off1;
    logic        dv1, ovf1;

    always #5 clk = ~clk;

    pwm_demodulator #(.N_PERIODS(N0), .ACC_W(24)) dut0 (
        .clk(clk), .reset(reset), .switch_pwm(switch_pwm),
        .sample_valid(sample_valid), .sample(sample),
        .demod(demod0), .on_count(on0), .off_count(off0),
        .demod_valid(dv0), .overflow(ovf0)
    );

    pwm_demodulator #(.N_PERIODS(N1), .ACC_W(12)) dut1 (
        .clk(clk), .reset(reset), .switch_pwm(switch_pwm),
        .sample_valid(sample_valid), .sample(sample),
        .demod(demod1), .on_count(on1), .off_count(off1),
        .demod_valid(dv1), .overflow(ovf1)
    );

    typedef struct packed {
        logic signed [63:0] demod;
        logic [15:0]        on_c;
        logic [15:0]        off_c;
        logic               ovf;
        logic [31:0]        cyc;
    } rep_t;

    rep_t exp0[$], exp1[$], got0[$], got1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: windows are counted in raw PWM rising edges; each
    // sample belongs to the window its edge count falls into and is classified
    // by the raw PWM level (stimulus keeps samples clear of edges, except the
    // deliberate sample that lands exactly on the detected edge).
    int     edges  = 0;
    bit     prev_p = 0;
    longint m_on[2], m_off[2];
    int     m_onc[2], m_offc[2];
    bit     m_ovf[2];
    int     m_n[2]    = '{N0, N1};
    longint m_max[2]  = '{longint'(16777215), longint'(4095)};

    task automatic tick(input bit rst, input bit p, input bit sv, input int smp);
        rep_t r;
        @(negedge clk);
        cyc++;
        if (dv0) begin
            r = '{longint'($signed(demod0)), on0, off0, ovf0, 32'(cyc)};
            got0.push_back(r);
        end
        if (dv1) begin
            r = '{longint'($signed(demod1)), on1, off1, ovf1, 32'(cyc)};
            got1.push_back(r);
        end
        reset        = rst;
        switch_pwm   = p;
        sample_valid = sv;
        sample       = 12'(smp);
        if (rst) begin
            edges  = 0;
            prev_p = 0;
        end else begin
            if (p && !prev_p) begin
                edges++;
                for (int k = 0; k < 2; k++) begin
                    if (edges == 1 || (edges - 1) % m_n[k] == 0) begin
                        if (edges > 1) begin
                            r = '{m_on[k] - m_off[k], 16'(m_onc[k]), 16'(m_offc[k]),
                                  m_ovf[k], 32'(cyc + 3)};
                            if (k == 0) exp0.push_back(r); else exp1.push_back(r);
                        end
                        m_on[k] = 0; m_off[k] = 0; m_onc[k] = 0; m_offc[k] = 0; m_ovf[k] = 0;
                    end
                end
            end
            prev_p = p;
            if (sv && edges > 0) begin
                for (int k = 0; k < 2; k++) begin
                    if (p) begin
                        if (m_on[k] + smp > m_max[k]) begin m_on[k] = m_max[k]; m_ovf[k] = 1; end
                        else m_on[k] += smp;
                        if (m_onc[k] == 65535) m_ovf[k] = 1; else m_onc[k]++;
                    end else begin
                        if (m_off[k] + smp > m_max[k]) begin m_off[k] = m_max[k]; m_ovf[k] = 1; end
                        else m_off[k] += smp;
                        if (m_offc[k] == 65535) m_ovf[k] = 1; else m_offc[k]++;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    // Drives np PWM periods. Samples sit at least 5 clk from either edge;
    // close_at/rst_at pick a period for an on-edge sample or a mid-low reset.
    task automatic run_periods(input int np, input int per, input int hi_w, input bit rnd,
                               input int a_hi, input int a_lo, input int close_at,
                               input int rst_at);
        for (int k = 0; k < np; k++) begin
            int pp, hh;
            pp = rnd ? int'($urandom_range(120, 30)) : per;
            hh = rnd ? int'($urandom_range(pp - 12, 12)) : hi_w;
            for (int t = 0; t < pp; t++) begin
                bit p, sv, safe;
                int smp;
                p    = (t < hh);
                safe = (t >= 5 && t <= hh - 5) || (t >= hh + 5 && t <= pp - 5);
                sv   = 0;
                smp  = 0;
                if (rnd) begin
                    if (safe && $urandom_range(2) == 0) begin
                        sv = 1; smp = int'($urandom_range(4095));
                    end
                end else if (safe && t % 10 == 5) begin
                    sv = 1; smp = p ? a_hi : a_lo;
                end
                if (k == close_at && t == 2) begin sv = 1; smp = a_hi; end
                if (k == rst_at && t == hh + (pp - hh) / 2) tick(1, p, 0, 0);
                else tick(0, p, sv, smp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({demod0, on0, off0, dv0, ovf0, demod1, on1, off1, dv1, ovf1} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got d0=%0h on0=%0d off0=%0d dv0=%0b ovf0=%0b d1=%0h, required all 0",
                     demod0, on0, off0, dv0, ovf0, demod1);
        end
        run_periods(9, 100, 50, 0, 12'h800, 12'h100, -1, -1);
        tests++;
        if (demod0 !== 25'd71680) begin
            fails++;
            $display("FAIL reset_pre_demod: got %0d required 71680", demod0);
        end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tests++;
        if ({demod0, on0, off0, dv0, ovf0, demod1, on1, off1, dv1, ovf1} !== '0) begin
            fails++;
            $display("FAIL reset_clears: got d0=%0d on0=%0d off0=%0d ovf0=%0b d1=%0d on1=%0d, required all 0",
                     demod0, on0, off0, ovf0, demod1, on1);
        end
    endtask

    task automatic test_nominal();
        rep_t g;
        do_reset();
        run_periods(17, 100, 50, 0, 12'h800, 12'h100, -1, -1);
        repeat (5) tick(0, 0, 0, 0);
        tests++;
        if (got0.size() != exp0.size() || exp0.size() != 2) begin
            fails++;
            $display("FAIL nom_reports: got %0d required %0d (model) and 2", got0.size(), exp0.size());
        end
        foreach (exp0[i]) begin
            g = (i < got0.size()) ? got0[i] : '0;
            tests++;
            if (g !== exp0[i]) begin
                fails++;
                $display("FAIL nom_rep%0d: got d=%0d on=%0d off=%0d ovf=%0b cyc=%0d required d=%0d on=%0d off=%0d ovf=%0b cyc=%0d",
                         i, g.demod, g.on_c, g.off_c, g.ovf, g.cyc, exp0[i].demod,
                         exp0[i].on_c, exp0[i].off_c, exp0[i].ovf, exp0[i].cyc);
            end
        end
        g = (got0.size() > 0) ? got0[0] : '0;
        tests++;
        if (g.demod !== 64'sd71680 || g.on_c !== 16'd40 || g.off_c !== 16'd40 || g.ovf !== 1'b0) begin
            fails++;
            $display("FAIL nom_values: got d=%0d on=%0d off=%0d ovf=%0b required 71680/40/40/0",
                     g.demod, g.on_c, g.off_c, g.ovf);
        end
        tests++;
        if (got0.size() < 2 || got0[1].cyc - got0[0].cyc !== 32'd800) begin
            fails++;
            $display("FAIL nom_interval: got %0d reports required 800 clk spacing", got0.size());
        end
        tests++;
        if ({demod0, on0, off0, ovf0, dv0} !== {25'd71680, 16'd40, 16'd40, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL nom_hold: got d=%0d on=%0d off=%0d ovf=%0b dv=%0b required 71680/40/40/0/0",
                     demod0, on0, off0, ovf0, dv0);
        end
    endtask

    task automatic test_inverted();
        rep_t g;
        do_reset();
        run_periods(9, 100, 50, 0, 12'h100, 12'h800, -1, -1);
        tests++;
        g = (got0.size() > 0) ? got0[0] : '0;
        if (got0.size() != 1 || g !== exp0[0] || g.demod !== -64'sd71680) begin
            fails++;
            $display("FAIL inv_demod: got n=%0d d=%0d on=%0d off=%0d required n=1 d=-71680 (model %0d)",
                     got0.size(), g.demod, g.on_c, g.off_c, exp0[0].demod);
        end
    endtask

    task automatic test_pre_edge();
        do_reset();
        for (int i = 0; i < 300; i++)
            tick(0, 0, ($urandom_range(3) == 0), int'($urandom_range(4095)));
        tests++;
        if (got0.size() != 0 || got1.size() != 0) begin
            fails++;
            $display("FAIL pre_edge_valid: got %0d/%0d pulses required 0", got0.size(), got1.size());
        end
        tests++;
        if ({demod0, on0, off0, ovf0, demod1, on1, off1, ovf1} !== '0) begin
            fails++;
            $display("FAIL pre_edge_outputs: got d0=%0d on0=%0d off0=%0d d1=%0d required 0",
                     demod0, on0, off0, demod1);
        end
    endtask

    task automatic test_close_sample();
        rep_t g;
        do_reset();
        run_periods(17, 100, 50, 0, 12'h800, 12'h100, 8, -1);
        tests++;
        if (got0.size() != exp0.size()) begin
            fails++;
            $display("FAIL close_reports: got %0d required %0d", got0.size(), exp0.size());
        end
        foreach (exp0[i]) begin
            g = (i < got0.size()) ? got0[i] : '0;
            tests++;
            if (g !== exp0[i]) begin
                fails++;
                $display("FAIL close_rep%0d: got d=%0d on=%0d off=%0d cyc=%0d required d=%0d on=%0d off=%0d cyc=%0d",
                         i, g.demod, g.on_c, g.off_c, g.cyc, exp0[i].demod, exp0[i].on_c,
                         exp0[i].off_c, exp0[i].cyc);
            end
        end
        tests++;
        if (got0.size() < 2 || got0[0].on_c !== 16'd40 || got0[1].on_c !== 16'd41) begin
            fails++;
            $display("FAIL close_on_count: got %0d reports, required on_count 40 then 41", got0.size());
        end
    endtask

    task automatic test_saturation();
        rep_t g;
        do_reset();
        run_periods(3, 100, 50, 0, 12'hFFF, 12'hFFF, -1, -1);
        run_periods(4, 100, 50, 0, 12'h001, 12'h001, -1, -1);
        tests++;
        if (got1.size() != exp1.size()) begin
            fails++;
            $display("FAIL sat_reports: got %0d required %0d", got1.size(), exp1.size());
        end
        foreach (exp1[i]) begin
            g = (i < got1.size()) ? got1[i] : '0;
            tests++;
            if (g !== exp1[i]) begin
                fails++;
                $display("FAIL sat_rep%0d: got d=%0d on=%0d off=%0d ovf=%0b required d=%0d on=%0d off=%0d ovf=%0b",
                         i, g.demod, g.on_c, g.off_c, g.ovf, exp1[i].demod, exp1[i].on_c,
                         exp1[i].off_c, exp1[i].ovf);
            end
        end
        tests++;
        if (got1.size() < 2 || got1[0].ovf !== 1'b1 || got1[1].ovf !== 1'b0) begin
            fails++;
            $display("FAIL sat_ovf_flags: got %0d reports, required overflow 1 then 0", got1.size());
        end
    endtask

    task automatic test_mid_reset();
        rep_t g;
        do_reset();
        run_periods(14, 100, 50, 0, 12'h800, 12'h100, -1, 4);
        tests++;
        if (got0.size() != 1 || exp0.size() != 1) begin
            fails++;
            $display("FAIL mid_reset_reports: got %0d required 1 (model %0d)", got0.size(), exp0.size());
        end
        g = (got0.size() > 0) ? got0[0] : '0;
        tests++;
        if (exp0.size() < 1 || g !== exp0[0]) begin
            fails++;
            $display("FAIL mid_reset_rep: got d=%0d on=%0d off=%0d cyc=%0d required d=%0d on=%0d off=%0d cyc=%0d",
                     g.demod, g.on_c, g.off_c, g.cyc, exp0[0].demod, exp0[0].on_c,
                     exp0[0].off_c, exp0[0].cyc);
        end
    endtask

    task automatic test_random();
        rep_t g;
        do_reset();
        run_periods(30, 0, 0, 1, 0, 0, -1, -1);
        tests++;
        if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            fails++;
            $display("FAIL rnd_reports: got %0d/%0d required %0d/%0d",
                     got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        foreach (exp0[i]) begin
            g = (i < got0.size()) ? got0[i] : '0;
            tests++;
            if (g !== exp0[i]) begin
                fails++;
                $display("FAIL rnd0_rep%0d: got d=%0d on=%0d off=%0d ovf=%0b cyc=%0d required d=%0d on=%0d off=%0d ovf=%0b cyc=%0d",
                         i, g.demod, g.on_c, g.off_c, g.ovf, g.cyc, exp0[i].demod,
                         exp0[i].on_c, exp0[i].off_c, exp0[i].ovf, exp0[i].cyc);
            end
        end
        foreach (exp1[i]) begin
            g = (i < got1.size()) ? got1[i] : '0;
            tests++;
            if (g !== exp1[i]) begin
                fails++;
                $display("FAIL rnd1_rep%0d: got d=%0d on=%0d off=%0d ovf=%0b cyc=%0d required d=%0d on=%0d off=%0d ovf=%0b cyc=%0d",
                         i, g.demod, g.on_c, g.off_c, g.ovf, g.cyc, exp1[i].demod,
                         exp1[i].on_c, exp1[i].off_c, exp1[i].ovf, exp1[i].cyc);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        switch_pwm   = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        test_reset();
        test_nominal();
        test_inverted();
        test_pre_edge();
        test_close_sample();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_demodulator.md
PWM_DEMODULATOR -- requirements
Module: pwm_demodulator

Consumes 12-bit ADC samples, splits them by switching-PWM phase, and reports on-minus-off sums over N PWM periods.

Interface
REQ-001 Parameter N_PERIODS, default 8, number of PWM periods per demodulation window; the legal range is 1..255.
REQ-002 Parameter ACC_W, default 24, width of each unsigned phase accumulator; the legal range is 12..30.
REQ-003 Port clk, input, 1 bit: system clock, 100 MHz; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port switch_pwm, input, 1 bit: switching PWM, asynchronous to clk.
REQ-006 Port sample_valid, input, 1 bit: one-clk strobe; sample is valid while it is high.
REQ-007 Port sample, input, 12 bits: unsigned ADC code (ADC data bits [15:4]).
REQ-008 Port demod, output, ACC_W+1 bits: two's-complement value on_sum minus off_sum for the last window.
REQ-009 Port on_count, output, 16 bits: number of samples accumulated while the PWM was high in the last window.
REQ-010 Port off_count, output, 16 bits: number of samples accumulated while the PWM was low in the last window.
REQ-011 Port demod_valid, output, 1 bit: one-clk pulse marking new demod, on_count, off_count and overflow.
REQ-012 Port overflow, output, 1 bit: set if any accumulator or count saturated in the last window.

Function
REQ-013 switch_pwm shall pass through a 2-flop synchronizer; its output is pwm_s, and pwm_d is pwm_s delayed by one clk.
REQ-014 rise shall equal pwm_s AND NOT pwm_d, computed combinationally.
REQ-015 The state machine shall have two states: WAIT_EDGE and ACCUM.
REQ-016 In WAIT_EDGE, samples shall be ignored; on rise, the block shall enter ACCUM with period_cnt set to 0 and the window started as defined in REQ-020.
REQ-017 In ACCUM, with sample_valid high and rise low, the sample shall be added to on_sum and on_cnt incremented if pwm_s is 1; otherwise to off_sum and off_cnt.
REQ-018 On a rise in ACCUM with period_cnt below N_PERIODS-1, period_cnt shall increment and a same-cycle sample shall be accumulated per REQ-017.
REQ-019 On a rise in ACCUM with period_cnt equal to N_PERIODS-1 (the closing edge), the next cycle shall register demod, on_count, off_count and overflow from the window state before that sample, and pulse demod_valid for one clk.
REQ-020 Window start (first edge or closing edge) shall:
- clear period_cnt, off_sum, off_cnt and the window overflow flag;
- load on_sum and on_cnt with the same-cycle sample and 1 if sample_valid is high, else with 0;
- keep the state in ACCUM, so there is no dead time between windows.
REQ-021 on_sum and off_sum shall saturate at 2^ACC_W-1 and on_cnt and off_cnt at 65535; any saturation event shall set the window overflow flag.
REQ-022 demod shall be computed as zero-extended on_sum minus zero-extended off_sum at ACC_W+1 bits, with no wrap.
REQ-023 Latency from a switch_pwm rising transition to the closing-edge rise shall be 2-3 clk; demod_valid follows 1 clk later.
REQ-024 Output registers shall hold their values between demod_valid pulses.
REQ-025 A sample arriving with pwm_s already updated shall be classified by pwm_s, not by the raw switch_pwm.

Reset
REQ-026 While reset is high at a clk edge:
- state goes to WAIT_EDGE;
- synchronizer flops, pwm_d, period_cnt, all sums, all counts and the window overflow flag are cleared to 0;
- demod, on_count, off_count, demod_valid and overflow are driven to 0.
REQ-027 A reset mid-window shall discard the partial window, with no demod_valid; accumulation restarts at the first rise after reset deasserts.
REQ-028 A rise in the cycle that reset is high shall be ignored.

Verification
REQ-029 Nominal window:
- stimulus: N=8, PWM period 100 clk, 50% duty; sample_valid every 10 clk, kept at least 5 clk from any PWM edge; sample 0x800 when high, 0x100 when low;
- response: demod_valid once per 800 clk, on_count=40, off_count=40, demod=71680, overflow=0.
REQ-030 Inverted amplitudes: same stimulus as REQ-029 with sample 0x100 high and 0x800 low -> demod = -71680 (two's complement).
REQ-031 Pre-edge samples: sample_valid pulses with switch_pwm held low after reset -> no accumulation, no demod_valid, all outputs stay 0.
REQ-032 Sample on the closing-edge cycle:
- stimulus: sample_valid asserted in the closing-edge cycle;
- response: the finished window excludes it, and the next window reports on_count one higher than the REQ-029 baseline.
REQ-033 Saturation: ACC_W=12, constant sample 0xFFF -> on_sum clamps at 4095 and the reported overflow=1; the following window with sample 0x001 reports overflow=0.
REQ-034 Mid-window reset: reset pulsed for 1 clk midway through a window -> no demod_valid for that window; the next report arrives N_PERIODS periods after the first post-reset rise.
